wb_commit_unit: RTL and testbench
=================================

Name: wb_commit_unit

Overview:
- Writeback/commit stage that drives the register file write port (write enable, destination pointer, write data).
- Arbitrates between two result producers: the single-cycle ALU and the multi-cycle load/store unit (LSU). Both use valid/ready handshakes.
- Holds a 32-entry busy scoreboard, so decode can stall on RAW hazards and on WAW hazards.
- Sits between the execute units and the register file. Registered outputs update on posedge and are stable when the register file samples them on negedge.

Parameters:
- DATA_W, 32, result/write data width.
- STARVE_MAX, 4, consecutive ALU losses before the ALU is granted priority (range 1..15).

Ports:
- i_CLK  in  1  clock; all state updates on posedge.
- i_RSTn  in  1  asynchronous, active-low reset.
- i_ISSUE_VALID  in  1  decode requests to mark a destination pending.
- i_ISSUE_RD_PTR  in  5  destination register of the issuing instruction.
- o_ISSUE_READY  out  1  issue accepted; low if the destination is already busy (WAW stall).
- i_RS1_PTR  in  5  source 1 pointer under hazard check.
- i_RS2_PTR  in  5  source 2 pointer under hazard check.
- o_RS1_BUSY  out  1  source 1 has a pending write.
- o_RS2_BUSY  out  1  source 2 has a pending write.
- i_ALU_VALID  in  1  ALU result valid.
- o_ALU_READY  out  1  ALU result accepted this cycle.
- i_ALU_RD_PTR  in  5  ALU destination.
- i_ALU_DATA  in  DATA_W  ALU result.
- i_LSU_VALID  in  1  LSU load result valid.
- o_LSU_READY  out  1  LSU result accepted this cycle.
- i_LSU_RD_PTR  in  5  LSU destination.
- i_LSU_DATA  in  DATA_W  LSU load data.
- o_WE  out  1  register file write enable (registered).
- o_RD_PTR  out  5  register file write pointer (registered).
- o_RD  out  DATA_W  register file write data (registered).

Behaviour:
- Reset (async, i_RSTn=0):
  - o_WE=0, o_RD_PTR=0, o_RD=0.
  - Scoreboard all clear; starvation counter=0; arbiter state LSU_PRI.
  - Combinational outputs then evaluate to o_ISSUE_READY=1 (when valid), o_RSx_BUSY=0.
  - Reset mid-operation discards any in-flight commit. Producers must re-present their results.
- Handshake:
  - A transfer occurs on the posedge where valid&ready=1.
  - Ready is combinational from the arbiter and never depends on the same source's data.
  - At most one source is accepted per cycle.
- Arbiter FSM, two states:
  - LSU_PRI: o_LSU_READY=i_LSU_VALID. o_ALU_READY=i_ALU_VALID & ~i_LSU_VALID.
  - ALU_PRI: mirror of LSU_PRI.
  - Counter increments when the ALU is valid but not granted. It clears when the ALU is granted.
  - Counter reaching STARVE_MAX moves to ALU_PRI. One ALU grant in ALU_PRI returns to LSU_PRI and clears the counter.
- Commit:
  - The accepted source registers into o_WE/o_RD_PTR/o_RD on the same posedge. The write takes effect at the following negedge. Latency is 1 cycle from handshake to o_WE.
  - No acceptance means o_WE=0 next cycle. o_RD_PTR and o_RD hold their values.
  - Destination x0: handshake completes, o_WE=0 (no write issued).
- Scoreboard:
  - busy[r] sets on issue handshake (i_ISSUE_VALID & o_ISSUE_READY), for r≠0.
  - busy[r] clears at the posedge ending the cycle where o_WE=1 and o_RD_PTR=r.
  - Set and clear of the same r on the same edge: set wins.
  - busy[0] is constant 0.
  - o_ISSUE_READY = ~busy[i_ISSUE_RD_PTR].
  - o_RSx_BUSY = busy[i_RSx_PTR]; pointer 0 always gives 0.
- Result for a register that is not busy: accepted and committed normally; busy is unaffected. The protocol error is left to verification assertions.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: o_RSx_BUSY is forced to 0 during a commit cycle whose o_RD_PTR matches i_RSx_PTR. The register file write at negedge makes the data readable in the same cycle.
- Undefined: busy stays asserted through the commit cycle, so dependents stall one extra cycle.

Decomposition:
- Shared package `cpu_pkg` holds:
  - the register index enum (zero..t6 ABI names),
  - REG_PTR_W=5 and NUM_REGS=32,
  - the arbiter state typedef (LSU_PRI/ALU_PRI).
- One sub-module, `wb_scoreboard`, holds the busy vector, the set/clear logic and the two hazard lookups. The top level holds the arbiter and the output register.

Test Plan:
- Reset asserted mid-commit (o_WE=1, rd=5) -> o_WE=0, o_RD_PTR=0, o_RD=0 immediately; busy[5]=0.
- Issue rd=7, then ALU valid rd=7 data=0xDEADBEEF -> o_ALU_READY=1. Next cycle o_WE=1, o_RD_PTR=7, o_RD=0xDEADBEEF. busy[7]=0 after that cycle. With i_RS1_PTR=7: o_RS1_BUSY=1 in the commit cycle unless WB_BYPASS_EN.
- ALU and LSU valid every cycle, STARVE_MAX=4 -> 4 LSU grants, then 1 ALU grant, then the pattern repeats.
- Issue rd=3 while busy[3]=1 -> o_ISSUE_READY=0. In the cycle the rd=3 commit clears and a new issue to rd=3 arrives on the same edge -> busy[3]=1 afterwards.
- LSU result to rd=0 data=0x1234 -> o_LSU_READY=1, o_WE=0 next cycle; i_RS1_PTR=0 gives o_RS1_BUSY=0.
- Back-to-back single ALU results rd=1,2,3 -> o_WE high 3 consecutive cycles with pointers 1,2,3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register ABI names,
// pointer widths and writeback arbiter state.
package cpu_pkg;

  localparam int REG_PTR_W = 5;
  localparam int NUM_REGS  = 32;

  typedef enum logic [REG_PTR_W-1:0] {
    zero, ra, sp, gp, tp,
    t0, t1, t2,
    s0, s1,
    a0, a1, a2, a3, a4, a5, a6, a7,
    s2, s3, s4, s5, s6, s7, s8, s9,
    s10, s11,
    t3, t4, t5, t6
  } reg_idx_e;

  typedef enum logic {
    LSU_PRI = 1'b0,
    ALU_PRI = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard for pending register writes.
// Optional WB_BYPASS_EN hides busy during the commit cycle.
module wb_scoreboard
  import cpu_pkg::*;
(
  input  logic                 i_CLK,
  input  logic                 i_RSTn,
  input  logic                 i_SET_EN,
  input  logic [REG_PTR_W-1:0] i_SET_PTR,
  input  logic                 i_CLR_EN,
  input  logic [REG_PTR_W-1:0] i_CLR_PTR,
  input  logic [REG_PTR_W-1:0] i_ISSUE_PTR,
  input  logic [REG_PTR_W-1:0] i_RS1_PTR,
  input  logic [REG_PTR_W-1:0] i_RS2_PTR,
  output logic                 o_ISSUE_BUSY,
  output logic                 o_RS1_BUSY,
  output logic                 o_RS2_BUSY
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                rs1_byp;
  logic                rs2_byp;

  // Set is applied after clear so a same-edge re-issue wins.
  always_comb begin
    busy_d = busy_q;
    if (i_CLR_EN) busy_d[i_CLR_PTR] = 1'b0;
    if (i_SET_EN) busy_d[i_SET_PTR] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

`ifdef WB_BYPASS_EN
  assign rs1_byp = i_CLR_EN && (i_CLR_PTR == i_RS1_PTR);
  assign rs2_byp = i_CLR_EN && (i_CLR_PTR == i_RS2_PTR);
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  assign o_ISSUE_BUSY = busy_q[i_ISSUE_PTR];
  assign o_RS1_BUSY   = busy_q[i_RS1_PTR] & ~rs1_byp;
  assign o_RS2_BUSY   = busy_q[i_RS2_PTR] & ~rs2_byp;

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: ALU/LSU arbiter, registered
// regfile write port and busy scoreboard (WB_BYPASS_EN optional).
module wb_commit_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 i_CLK,
  input  logic                 i_RSTn,
  input  logic                 i_ISSUE_VALID,
  input  logic [REG_PTR_W-1:0] i_ISSUE_RD_PTR,
  output logic                 o_ISSUE_READY,
  input  logic [REG_PTR_W-1:0] i_RS1_PTR,
  input  logic [REG_PTR_W-1:0] i_RS2_PTR,
  output logic                 o_RS1_BUSY,
  output logic                 o_RS2_BUSY,
  input  logic                 i_ALU_VALID,
  output logic                 o_ALU_READY,
  input  logic [REG_PTR_W-1:0] i_ALU_RD_PTR,
  input  logic [DATA_W-1:0]    i_ALU_DATA,
  input  logic                 i_LSU_VALID,
  output logic                 o_LSU_READY,
  input  logic [REG_PTR_W-1:0] i_LSU_RD_PTR,
  input  logic [DATA_W-1:0]    i_LSU_DATA,
  output logic                 o_WE,
  output logic [REG_PTR_W-1:0] o_RD_PTR,
  output logic [DATA_W-1:0]    o_RD
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM =
    CNT_W'(STARVE_MAX);

  arb_state_e           state_q;
  arb_state_e           state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 alu_gnt;
  logic                 lsu_gnt;
  logic                 we_q;
  logic                 we_d;
  logic [REG_PTR_W-1:0] rd_ptr_q;
  logic [REG_PTR_W-1:0] rd_ptr_d;
  logic [DATA_W-1:0]    rd_q;
  logic [DATA_W-1:0]    rd_d;
  logic                 issue_busy;

  always_comb begin
    alu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    unique case (state_q)
      LSU_PRI: begin
        lsu_gnt = i_LSU_VALID;
        alu_gnt = i_ALU_VALID & ~i_LSU_VALID;
      end
      ALU_PRI: begin
        alu_gnt = i_ALU_VALID;
        lsu_gnt = i_LSU_VALID & ~i_ALU_VALID;
      end
    endcase
  end

  // Count ALU losses; one ALU win hands priority back.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (alu_gnt) begin
      cnt_d   = '0;
      state_d = LSU_PRI;
    end else if (i_ALU_VALID) begin
      if (cnt_q != STARVE_LIM) cnt_d = cnt_q + 1'b1;
      if (cnt_d == STARVE_LIM) state_d = ALU_PRI;
    end
  end

  always_comb begin
    we_d     = 1'b0;
    rd_ptr_d = rd_ptr_q;
    rd_d     = rd_q;
    unique case (1'b1)
      alu_gnt: begin
        we_d     = (i_ALU_RD_PTR != zero);
        rd_ptr_d = i_ALU_RD_PTR;
        rd_d     = i_ALU_DATA;
      end
      lsu_gnt: begin
        we_d     = (i_LSU_RD_PTR != zero);
        rd_ptr_d = i_LSU_RD_PTR;
        rd_d     = i_LSU_DATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q  <= LSU_PRI;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      rd_ptr_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      rd_ptr_q <= rd_ptr_d;
      rd_q     <= rd_d;
    end
  end

  wb_scoreboard u_sb (
    .i_CLK        (i_CLK),
    .i_RSTn       (i_RSTn),
    .i_SET_EN     (i_ISSUE_VALID & o_ISSUE_READY),
    .i_SET_PTR    (i_ISSUE_RD_PTR),
    .i_CLR_EN     (we_q),
    .i_CLR_PTR    (rd_ptr_q),
    .i_ISSUE_PTR  (i_ISSUE_RD_PTR),
    .i_RS1_PTR    (i_RS1_PTR),
    .i_RS2_PTR    (i_RS2_PTR),
    .o_ISSUE_BUSY (issue_busy),
    .o_RS1_BUSY   (o_RS1_BUSY),
    .o_RS2_BUSY   (o_RS2_BUSY)
  );

  assign o_ISSUE_READY = ~issue_busy;
  assign o_ALU_READY   = alu_gnt;
  assign o_LSU_READY   = lsu_gnt;
  assign o_WE          = we_q;
  assign o_RD_PTR      = rd_ptr_q;
  assign o_RD          = rd_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Random + directed bench for wb_commit_unit with a
// queue scoreboard and a rule-level reference model.
module tb_wb_commit_unit;

  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iss_v = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        iss_rdy;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        rs1_b;
  logic        rs2_b;
  logic        alu_v = 1'b0;
  logic        alu_rdy;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_d = '0;
  logic        lsu_v = 1'b0;
  logic        lsu_rdy;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_d = '0;
  logic        we;
  logic [4:0]  wptr;
  logic [31:0] wdata;

  always #5 clk = ~clk;

  wb_commit_unit #(.DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .i_CLK(clk), .i_RSTn(rst_n),
    .i_ISSUE_VALID(iss_v), .i_ISSUE_RD_PTR(iss_rd),
    .o_ISSUE_READY(iss_rdy),
    .i_RS1_PTR(rs1), .i_RS2_PTR(rs2),
    .o_RS1_BUSY(rs1_b), .o_RS2_BUSY(rs2_b),
    .i_ALU_VALID(alu_v), .o_ALU_READY(alu_rdy),
    .i_ALU_RD_PTR(alu_rd), .i_ALU_DATA(alu_d),
    .i_LSU_VALID(lsu_v), .o_LSU_READY(lsu_rdy),
    .i_LSU_RD_PTR(lsu_rd), .i_LSU_DATA(lsu_d),
    .o_WE(we), .o_RD_PTR(wptr), .o_RD(wdata)
  );

  typedef struct {
    logic [4:0]  ptr;
    logic [31:0] data;
    longint      t;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  bit [31:0] m_busy;
  bit        m_pend_we;
  bit [4:0]  m_pend_ptr;
  int        m_losses;

  bit g_alu, g_lsu, g_ir, g_rs1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit m_rs_busy(input bit [4:0] p);
    bit b;
    b = m_busy[p] && (p != 0);
`ifdef WB_BYPASS_EN
    if (m_pend_we && m_pend_ptr == p) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic model_reset();
    m_busy = '0;
    m_pend_we = 1'b0;
    m_pend_ptr = '0;
    m_losses = 0;
    q.delete();
  endtask

  task automatic cycle(input bit iv, input bit [4:0] ird,
                       input bit [4:0] r1, input bit [4:0] r2,
                       input bit av, input bit [4:0] ard,
                       input bit [31:0] ad,
                       input bit lv, input bit [4:0] lrd,
                       input bit [31:0] ld);
    bit e_ag, e_lg, e_ir;
    bit [4:0] p;
    bit [31:0] d;
    exp_t e;
    @(negedge clk);
    iss_v = iv; iss_rd = ird; rs1 = r1; rs2 = r2;
    alu_v = av; alu_rd = ard; alu_d = ad;
    lsu_v = lv; lsu_rd = lrd; lsu_d = ld;
    #1;
    e_ir = !m_busy[ird];
    if (m_losses >= STARVE_MAX) begin
      e_ag = av;
      e_lg = lv && !av;
    end else begin
      e_lg = lv;
      e_ag = av && !lv;
    end
    chk("alu_ready", alu_rdy, e_ag);
    chk("lsu_ready", lsu_rdy, e_lg);
    chk("issue_ready", iss_rdy, e_ir);
    chk("rs1_busy", rs1_b, m_rs_busy(r1));
    chk("rs2_busy", rs2_b, m_rs_busy(r2));
    g_alu = alu_rdy; g_lsu = lsu_rdy;
    g_ir = iss_rdy; g_rs1 = rs1_b;
    @(posedge clk);
    if (m_pend_we) m_busy[m_pend_ptr] = 1'b0;
    if (iv && e_ir && ird != 0) m_busy[ird] = 1'b1;
    m_pend_we = 1'b0;
    if (e_ag || e_lg) begin
      p = e_ag ? ard : lrd;
      d = e_ag ? ad : ld;
      if (p != 0) begin
        m_pend_we = 1'b1;
        m_pend_ptr = p;
        e.ptr = p; e.data = d; e.t = longint'($time);
        q.push_back(e);
      end
    end
    if (e_ag) m_losses = 0;
    else if (av) m_losses++;
  endtask

  task automatic idle(input bit [4:0] r1);
    cycle(0, 0, r1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every write the DUT presents must match the queue head.
  initial begin
    exp_t e;
    longint now;
    forever begin
      @(posedge clk);
      #1;
      now = longint'($time) - 1;
      if (rst_n) begin
        while (q.size() > 0 && q[0].t < now) begin
          e = q.pop_front();
          chk("missing_commit", 32'(e.t), 32'(now));
        end
        if (we) begin
          if (q.size() == 0) begin
            chk("unexpected_write", {27'd0, wptr}, 32'd0);
          end else begin
            e = q.pop_front();
            chk("commit_ptr", {27'd0, wptr}, {27'd0, e.ptr});
            chk("commit_data", wdata, e.data);
            chk("commit_time", 32'(now), 32'(e.t));
          end
        end
      end
    end
  end

  initial begin
    bit [9:0] g;
    model_reset();
    iss_rd = 5'd5;
    rs1 = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", we, 0);
    chk("rst_ptr", wptr, 0);
    chk("rst_rd", wdata, 0);
    chk("rst_issue_ready", iss_rdy, 1);
    chk("rst_rs1_busy", rs1_b, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both producers saturating: 4 LSU wins then 1 ALU win.
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 1, 0, $urandom, 1, 9, $urandom);
      g[i] = g_alu;
    end
    chk("starve_pattern", 32'(g), 32'b1000010000);

    // Issue rd7, ALU commit 0xDEADBEEF, check busy timing.
    cycle(1, 7, 7, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 7, 0, 1, 7, 32'hDEADBEEF, 0, 0, 0);
    chk("rd7_alu_ready", g_alu, 1);
    chk("rd7_busy_pre", g_rs1, 1);
    #1;
    chk("rd7_we", we, 1);
    chk("rd7_ptr", wptr, 7);
    chk("rd7_data", wdata, 32'hDEADBEEF);
    idle(7);
`ifdef WB_BYPASS_EN
    chk("rd7_busy_commit", g_rs1, 0);
`else
    chk("rd7_busy_commit", g_rs1, 1);
`endif
    idle(7);
    chk("rd7_busy_post", g_rs1, 0);

    // WAW stall and same-edge set/clear on rd3.
    cycle(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 3, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("waw_stall", g_ir, 0);
    cycle(0, 0, 3, 0, 1, 3, 32'h0000_0033, 0, 0, 0);
    cycle(1, 3, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("waw_commit_cycle", g_ir, 0);
    idle(3);
    chk("rd3_cleared", g_rs1, 0);
    cycle(0, 0, 3, 0, 1, 3, 32'h0000_0333, 0, 0, 0);
    cycle(1, 3, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("setclr_issue_ready", g_ir, 1);
    idle(3);
    chk("set_wins", g_rs1, 1);
    cycle(0, 0, 0, 0, 1, 3, 32'h3, 0, 0, 0);
    idle(0);

    // LSU result to x0: accepted, no write.
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1234);
    chk("x0_lsu_ready", g_lsu, 1);
    chk("x0_rs1_busy", g_rs1, 0);
    #1;
    chk("x0_we", we, 0);

    // Back-to-back ALU results rd 1,2,3.
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 0, 0, 0, 1, 5'(i), 32'h100 + i, 0, 0, 0);
      #1;
      chk("b2b_we", we, 1);
      chk("b2b_ptr", wptr, i);
    end
    idle(0);

    // Reset during a commit cycle.
    cycle(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 5, 32'h5555_AAAA, 0, 0, 0);
    #1;
    chk("mid_we_pre", we, 1);
    chk("mid_ptr_pre", wptr, 5);
    #1;
    rst_n = 1'b0;
    model_reset();
    iss_v = 0; alu_v = 0; lsu_v = 0;
    rs1 = 5'd5; iss_rd = 5'd5;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_ptr", wptr, 0);
    chk("mid_rst_rd", wdata, 0);
    chk("mid_rst_busy5", rs1_b, 0);
    chk("mid_rst_issue5", iss_rdy, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)),
            $urandom,
            $urandom_range(0, 9) < 5, 5'($urandom_range(0, 7)),
            $urandom);
    end
    repeat (3) idle(0);
    #2;
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
